// File: rtl/uart_pkg.sv
// Shared UART definitions: baud divisors, frame geometry and receiver FSM state encoding.
// Latency: none. This package holds constants and pure functions only.
// Backpressure: not applicable.
//
// Contents:
//   B<rate>    clock cycles per bit for a 12 MHz system clock (same values as baudgen.vh)
//   DATA_BITS  payload bits per frame
//   IDLE..STOP receiver FSM state encoding
//   even_par   even-parity helper

package uart_pkg;

  // Baud divisors: clock cycles per serial bit at 12 MHz.
  localparam int B115200 = 104;
  localparam int B57600  = 208;
  localparam int B38400  = 313;
  localparam int B19200  = 625;
  localparam int B9600   = 1250;
  localparam int B4800   = 2500;
  localparam int B2400   = 5000;
  localparam int B1200   = 10000;
  localparam int B600    = 20000;
  localparam int B300    = 40000;

  // Frame geometry.
  localparam int DATA_BITS = 8;
  localparam int BIT_IDX_W = $clog2(DATA_BITS);

  // Receiver FSM states. Plain constants keep the encoding stable for older tooling.
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  // Even parity: the parity bit that makes the total count of ones even.
  function automatic logic even_par(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/baudgen_rx.sv
// Receive-side bit-timing generator: one-cycle tick at the centre of every serial bit.
// Latency: first tick BAUDRATE/2 cycles after clk_ena rises, then one tick every BAUDRATE cycles.
// Backpressure: none. While clk_ena is low the counter is parked and produces no ticks.
//
// Ports:
//   clk      in  system clock
//   rstn     in  asynchronous active-low reset
//   clk_ena  in  high while a frame is being received
//   clk_out  out one-cycle sample tick

module baudgen_rx
  import uart_pkg::*;
#(
  parameter int BAUDRATE = B115200
) (
  input  logic clk,
  input  logic rstn,
  input  logic clk_ena,
  output logic clk_out
);

  localparam int CW = (BAUDRATE > 2) ? $clog2(BAUDRATE) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(BAUDRATE - 1);
  localparam logic [CW-1:0] HALF   = CW'(BAUDRATE / 2 - 1);

  logic [CW-1:0] cnt;

  // Parked at the half-bit value while disabled. The first tick after enable
  // therefore lands in the middle of the start bit, and every later tick lands
  // in the middle of a data bit.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (!clk_ena) begin
      cnt <= HALF;
    end else if (cnt == '0) begin
      cnt <= RELOAD;
    end else begin
      cnt <= cnt - CW'(1);
    end
  end

  assign clk_out = clk_ena && (cnt == '0);

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1 (8E1 with UART_RX_PARITY_EN), LSB first, oversampled by the system clock.
// Latency: rcv about 2 + BAUDRATE/2 + 9*BAUDRATE + 1 cycles after the start edge (+BAUDRATE with parity).
// Backpressure: none. A byte the consumer misses is overwritten by the next frame.
//
// Ports:
//   clk   in   system clock
//   rstn  in   asynchronous active-low reset
//   rx    in   serial line, idle high, asynchronous to clk
//   rcv   out  one-cycle strobe: new byte on data
//   data  out  last received byte, held until the next frame completes
//   ferr  out  framing error of the last frame (stop bit sampled low)
//   perr  out  parity error of the last frame (only with UART_RX_PARITY_EN)
//
// Build option: define UART_RX_PARITY_EN to receive one even-parity bit after the data bits.

module uart_rx
  import uart_pkg::*;
#(
  parameter int BAUDRATE = B115200
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 rx,
  output logic                 rcv,
  output logic [DATA_BITS-1:0] data,
  output logic                 ferr
`ifdef UART_RX_PARITY_EN
  ,
  output logic                 perr
`endif
);

  localparam logic [BIT_IDX_W-1:0] LAST_BIT = BIT_IDX_W'(DATA_BITS - 1);

  // Two-flop synchronizer. It resets to the idle level so that reset release
  // is never mistaken for a start bit.
  logic rx_meta;
  logic rx_s;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // Bit timing.
  logic [2:0] state;
  logic       baud_ena;
  logic       tick;

  // The generator runs only outside IDLE. While in IDLE it re-arms itself with
  // the half-bit delay, which provides the start-bit centring.
  assign baud_ena = (state != IDLE);

  baudgen_rx #(
    .BAUDRATE (BAUDRATE)
  ) u_baudgen (
    .clk     (clk),
    .rstn    (rstn),
    .clk_ena (baud_ena),
    .clk_out (tick)
  );

  // Receive FSM and shift register.
  logic [BIT_IDX_W-1:0] bit_idx;
  logic [DATA_BITS-1:0] shift;
`ifdef UART_RX_PARITY_EN
  logic                 par_bit;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      bit_idx <= '0;
      shift   <= '0;
`ifdef UART_RX_PARITY_EN
      par_bit <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
          end
        end

        START: begin
          if (tick) begin
            // A line that is back high at mid-start-bit was only a glitch.
            if (rx_s) begin
              state <= IDLE;
            end else begin
              state   <= DATA;
              bit_idx <= '0;
            end
          end
        end

        DATA: begin
          if (tick) begin
            // The LSB arrives first: shift right and enter at the top bit.
            shift   <= {rx_s, shift[DATA_BITS-1:1]};
            bit_idx <= bit_idx + BIT_IDX_W'(1);
            if (bit_idx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tick) begin
            par_bit <= rx_s;
            state   <= STOP;
          end
        end
`endif

        STOP: begin
          // Returning to IDLE at mid-stop-bit leaves half a bit of margin.
          // That margin lets a back-to-back start edge be caught on time.
          if (tick) begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  // Output registers. They load only at the stop-bit sample and otherwise
  // hold the last frame.
  logic stop_tick;
  assign stop_tick = (state == STOP) && tick;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rcv  <= 1'b0;
      data <= '0;
      ferr <= 1'b0;
    end else begin
      rcv <= stop_tick;
      if (stop_tick) begin
        data <= shift;
        ferr <= ~rx_s;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      perr <= 1'b0;
    end else if (stop_tick) begin
      perr <= even_par(shift) ^ par_bit;
    end
  end
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: a behavioural serial transmitter drives rx,
// and every received byte is matched against a queue of what was sent.

module tb_uart_rx;

  localparam int BAUD = 16;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  // From the start edge: synchronizer, half bit, then up to the middle of the stop bit, then the output register.
  localparam int LAT = 2 + BAUD / 2 + (FRAME_BITS - 1) * BAUD + 1;

  logic       clk;
  logic       rstn;
  logic       rx;
  logic       rcv;
  logic [7:0] data;
  logic       ferr;
`ifdef UART_RX_PARITY_EN
  logic       perr;
`endif

  uart_rx #(
    .BAUDRATE (BAUD)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .rx   (rx),
    .rcv  (rcv),
    .data (data),
    .ferr (ferr)
`ifdef UART_RX_PARITY_EN
    ,
    .perr (perr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] d;
    logic       f;
    logic       p;
    int         c;
  } frame_t;

  frame_t cap_q[$];
  frame_t exp_q[$];

  // Capture every strobe. A strobe held too long shows up as extra captures.
  always @(negedge clk) begin
    if (rcv === 1'b1) begin
`ifdef UART_RX_PARITY_EN
      cap_q.push_back('{d: data, f: ferr, p: perr, c: cyc});
`else
      cap_q.push_back('{d: data, f: ferr, p: 1'b0, c: cyc});
`endif
    end
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Hold the line at v for n clock cycles. Each call starts just after a rising edge.
  task automatic hold(input logic v, input int n);
    rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Transmitter model: start bit, LSB-first data, optional parity bit, stop bit.
  // Records the expected result for the frame.
  task automatic send(input logic [7:0] b, input logic stop, input logic par);
    hold(1'b0, BAUD);
    for (int i = 0; i < 8; i++) hold(b[i], BAUD);
`ifdef UART_RX_PARITY_EN
    hold(par, BAUD);
`endif
    hold(stop, BAUD);
    exp_q.push_back('{d: b, f: ~stop, p: par ^ (^b), c: 0});
  endtask

  task automatic check_caps(input string tag);
    int n;
    chk({tag, "_cnt"}, cap_q.size(), exp_q.size());
    n = (cap_q.size() < exp_q.size()) ? cap_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_data%0d", tag, i), cap_q[i].d, exp_q[i].d);
      chk($sformatf("%s_ferr%0d", tag, i), cap_q[i].f, exp_q[i].f);
`ifdef UART_RX_PARITY_EN
      chk($sformatf("%s_perr%0d", tag, i), cap_q[i].p, exp_q[i].p);
`endif
    end
    cap_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int lat;
    logic [7:0] b;
    logic stop;
    logic par;
    int gap;

    rstn = 1'b0;
    rx   = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_rcv", rcv, 1'b0);
    chk("reset_data", data, 8'h00);
    chk("reset_ferr", ferr, 1'b0);
`ifdef UART_RX_PARITY_EN
    chk("reset_perr", perr, 1'b0);
`endif
    @(posedge clk);
    #1;
    rstn = 1'b1;
    hold(1'b1, 4 * BAUD);

    // Test 1: single frame, with a latency check.
    t0 = cyc;
    send(8'h41, 1'b1, ^8'h41);
    hold(1'b1, 3 * BAUD);
    if (cap_q.size() > 0) begin
      lat = cap_q[0].c - t0;
      chk($sformatf("t1_latency_%0d", lat), (lat >= LAT - 2) && (lat <= LAT + 2), 1'b1);
    end
    check_caps("t1");

    // Test 2: back-to-back frames with no idle gap.
    send(8'h55, 1'b1, ^8'h55);
    send(8'hAA, 1'b1, ^8'hAA);
    hold(1'b1, 3 * BAUD);
    if (cap_q.size() == 2) begin
      chk("t2_spacing", cap_q[1].c - cap_q[0].c, FRAME_BITS * BAUD);
    end
    check_caps("t2");

    // Test 3: a short glitch must not produce a byte.
    hold(1'b0, 5);
    hold(1'b1, 4 * BAUD);
    @(negedge clk);
    chk("t3_no_rcv", cap_q.size(), 0);
    chk("t3_data_hold", data, 8'hAA);
    chk("t3_ferr_hold", ferr, 1'b0);
    @(posedge clk);
    #1;
    send(8'h30, 1'b1, ^8'h30);
    hold(1'b1, 3 * BAUD);
    check_caps("t3");

    // Test 5: reset in the middle of bit 4 of 8'h96.
    b = 8'h96;
    hold(1'b0, BAUD);
    for (int i = 0; i < 4; i++) hold(b[i], BAUD);
    hold(b[4], BAUD / 2);
    rstn = 1'b0;
    rx   = 1'b1;
    @(negedge clk);
    chk("t5_rst_rcv", rcv, 1'b0);
    chk("t5_rst_data", data, 8'h00);
    chk("t5_rst_ferr", ferr, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    rstn = 1'b1;
    hold(1'b1, 2 * BAUD);
    send(8'h3C, 1'b1, ^8'h3C);
    hold(1'b1, 3 * BAUD);
    check_caps("t5");

    // Test 4: framing error, then a good frame clears it.
    send(8'hFF, 1'b0, ^8'hFF);
    hold(1'b1, 2 * BAUD);
    send(8'h00, 1'b1, ^8'h00);
    hold(1'b1, 3 * BAUD);
    check_caps("t4");

`ifdef UART_RX_PARITY_EN
    // Test 6: parity checking.
    send(8'h07, 1'b1, 1'b1);
    hold(1'b1, BAUD);
    send(8'h07, 1'b1, 1'b0);
    hold(1'b1, 3 * BAUD);
    check_caps("t6");
`endif

    // Randomized frames. After a bad stop bit the line idles for at least one
    // bit, so the next start edge is unambiguous.
    for (int k = 0; k < 24; k++) begin
      b    = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 3) != 0);
      par  = ($urandom_range(0, 3) != 0) ? ^b : ~(^b);
      gap  = stop ? $urandom_range(0, 2) : 1 + $urandom_range(0, 1);
      send(b, stop, par);
      hold(1'b1, gap * BAUD);
    end
    hold(1'b1, 3 * BAUD);
    check_caps("rnd");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
